// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and constants for the SPI target
package spi_target_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;
    localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Byte presented at a boundary: holding register if loaded, else the filler byte.
    function automatic logic [BYTE_W-1:0] pick_source(
        input logic              full,
        input logic [BYTE_W-1:0] hold,
        input logic [BYTE_W-1:0] idle
    );
        return full ? hold : idle;
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - multi-flop input synchronizer with rise/fall pulses
module spi_target_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - oversampled SPI target, 8-bit MSB-first frames, mode 0
// SPI_TARGET_MODE3_EN adds a MODE3 input selecting CPOL=1/CPHA=1.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              nSS,
`ifdef SPI_TARGET_MODE3_EN
    input  logic              MODE3,
`endif
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [BYTE_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic [BYTE_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              TX_UNDERRUN,
    output logic              SEL
);

    logic sck_s, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic mode3_w;
    logic unused_sync_levels;

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk_i   (CLK),
        .resetn_i(nRESET),
        .d_i     (SCK),
        .level_o (sck_s),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk_i   (CLK),
        .resetn_i(nRESET),
        .d_i     (nSS),
        .level_o (ss_s),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i   (CLK),
        .resetn_i(nRESET),
        .d_i     (MOSI),
        .level_o (mosi_s),
        .rise_o  (mosi_rise),
        .fall_o  (mosi_fall)
    );

    assign unused_sync_levels = &{1'b0, sck_s, ss_s, mosi_rise, mosi_fall};

`ifdef SPI_TARGET_MODE3_EN
    assign mode3_w = MODE3;
`else
    assign mode3_w = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]  rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               tx_underrun_q, tx_underrun_d;
    logic               miso_q, miso_d;
    logic [BYTE_W-1:0]  hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [BYTE_W-1:0]  peek_q, peek_d;
    logic               peek_hold_q, peek_hold_d;
    logic [BYTE_W-1:0]  tx_shift_q, tx_shift_d;
    logic               skip_fall_q, skip_fall_d;
    logic [BYTE_W-1:0]  src_byte;

    assign src_byte = pick_source(hold_full_q, hold_q, IDLE_BYTE);

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        miso_d        = miso_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        peek_d        = peek_q;
        peek_hold_d   = peek_hold_q;
        tx_shift_d    = tx_shift_q;
        skip_fall_d   = skip_fall_q;

        if (TX_VALID && !hold_full_q) begin
            hold_d      = TX_DATA;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d    = 1'b1;
                bit_cnt_d = '0;
                if (ss_fall) begin
                    state_d     = ST_ACTIVE;
                    peek_d      = src_byte;
                    peek_hold_d = hold_full_q;
                    miso_d      = src_byte[BYTE_W-1];
                    skip_fall_d = mode3_w;
                    rx_shift_d  = '0;
                end
            end
            ST_ACTIVE: begin
                // Deselect wins over any SCK edge seen in the same cycle.
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    miso_d      = 1'b1;
                    rx_shift_d  = '0;
                    skip_fall_d = 1'b0;
                end else if (sck_rise) begin
                    rx_shift_d  = {rx_shift_q[BYTE_W-3:0], mosi_s};
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                    skip_fall_d = 1'b0;
                    if (bit_cnt_q == '0) begin
                        tx_shift_d = peek_q;
                        if (peek_hold_q) begin
                            hold_full_d = 1'b0;
                        end else begin
                            tx_underrun_d = 1'b1;
                        end
                    end
                    if (bit_cnt_q == CNT_W'(BYTE_W-1)) begin
                        rx_data_d  = {rx_shift_q, mosi_s};
                        rx_valid_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (skip_fall_q) begin
                        skip_fall_d = 1'b0;
                    end else if (bit_cnt_q == '0) begin
                        peek_d      = src_byte;
                        peek_hold_d = hold_full_q;
                        miso_d      = src_byte[BYTE_W-1];
                    end else begin
                        miso_d = tx_shift_q[CNT_W'(BYTE_W-1) - bit_cnt_q];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            miso_q        <= 1'b1;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            peek_q        <= '0;
            peek_hold_q   <= 1'b0;
            tx_shift_q    <= '0;
            skip_fall_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            miso_q        <= miso_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            peek_q        <= peek_d;
            peek_hold_q   <= peek_hold_d;
            tx_shift_q    <= tx_shift_d;
            skip_fall_q   <= skip_fall_d;
        end
    end

    assign MISO        = miso_q;
    assign MISO_OE     = (state_q == ST_ACTIVE);
    assign SEL         = (state_q == ST_ACTIVE);
    assign TX_READY    = ~hold_full_q;
    assign RX_DATA     = rx_data_q;
    assign RX_VALID    = rx_valid_q;
    assign TX_UNDERRUN = tx_underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - directed, table-driven bench for spi_target
module tb_spi_target;

    localparam int HALF = 6;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       SCK = 1'b0;
    logic       MOSI = 1'b0;
    logic       nSS = 1'b1;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_VALID = 1'b0;
    logic       MISO, MISO_OE, TX_READY, RX_VALID, TX_UNDERRUN, SEL;
    logic [7:0] RX_DATA;
`ifdef SPI_TARGET_MODE3_EN
    logic       MODE3 = 1'b0;
`endif

    spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .SCK        (SCK),
        .MOSI       (MOSI),
        .nSS        (nSS),
`ifdef SPI_TARGET_MODE3_EN
        .MODE3      (MODE3),
`endif
        .MISO       (MISO),
        .MISO_OE    (MISO_OE),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .RX_DATA    (RX_DATA),
        .RX_VALID   (RX_VALID),
        .TX_UNDERRUN(TX_UNDERRUN),
        .SEL        (SEL)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int rx_cnt = 0;
    int und_cnt = 0;

    always @(negedge CLK) begin
        if (RX_VALID === 1'b1) rx_cnt++;
        if (TX_UNDERRUN === 1'b1) und_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(input logic [7:0] d);
        int t = 0;
        while (TX_READY !== 1'b1 && t < 50) begin
            wclk(1);
            t++;
        end
        check("load_ready_wait", (t < 50) ? 32'd1 : 32'd0, 32'd1);
        TX_DATA  = d;
        TX_VALID = 1'b1;
        wclk(1);
        TX_VALID = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] mosi_b, input logic cpol, input int nbits,
                        output logic [7:0] miso_b, output logic rdy_pre, output logic rdy_post);
        miso_b = 8'h00;
        rdy_pre = 1'b0;
        rdy_post = 1'b0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (cpol) SCK = 1'b0;
            MOSI = mosi_b[i];
            wclk(HALF);
            if (i == 7) rdy_pre = TX_READY;
            miso_b[i] = MISO;
            SCK = 1'b1;
            wclk(HALF);
            if (i == 7) rdy_post = TX_READY;
            if (!cpol) SCK = 1'b0;
        end
    endtask

    task automatic select_t();
        nSS = 1'b0;
        wclk(HALF);
    endtask

    task automatic deselect_t();
        wclk(HALF);
        nSS = 1'b1;
        wclk(HALF);
    endtask

    typedef struct {
        logic       load;
        logic [7:0] hold;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] m1, m2;
    logic       p0, p1;

    initial begin
        vecs[0] = '{load: 1'b1, hold: 8'h3C, mosi: 8'hA5, exp_miso: 8'h3C, exp_und: 0};
        vecs[1] = '{load: 1'b0, hold: 8'h00, mosi: 8'h00, exp_miso: 8'hFF, exp_und: 1};
        vecs[2] = '{load: 1'b1, hold: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_und: 0};
        vecs[3] = '{load: 1'b1, hold: 8'h81, mosi: 8'h5A, exp_miso: 8'h81, exp_und: 0};

        wclk(4);
        nRESET = 1'b1;
        wclk(2);
        check("rst_miso", 32'(MISO), 32'd1);
        check("rst_miso_oe", 32'(MISO_OE), 32'd0);
        check("rst_tx_ready", 32'(TX_READY), 32'd1);
        check("rst_rx_data", 32'(RX_DATA), 32'h00);
        check("rst_rx_valid", 32'(RX_VALID), 32'd0);
        check("rst_underrun", 32'(TX_UNDERRUN), 32'd0);
        check("rst_sel", 32'(SEL), 32'd0);

        for (int v = 0; v < 4; v++) begin
            rx_cnt = 0;
            und_cnt = 0;
            if (vecs[v].load) load(vecs[v].hold);
            select_t();
            xfer(vecs[v].mosi, 1'b0, 8, m1, p0, p1);
            deselect_t();
            check($sformatf("vec%0d_miso", v), 32'(m1), 32'(vecs[v].exp_miso));
            check($sformatf("vec%0d_rx_data", v), 32'(RX_DATA), 32'(vecs[v].mosi));
            check($sformatf("vec%0d_rx_pulses", v), 32'(rx_cnt), 32'd1);
            check($sformatf("vec%0d_underruns", v), 32'(und_cnt), 32'(vecs[v].exp_und));
            check($sformatf("vec%0d_ready_pre", v), 32'(p0), 32'(!vecs[v].load));
            check($sformatf("vec%0d_ready_post", v), 32'(p1), 32'd1);
        end

        // Two bytes with nothing loaded: filler byte twice.
        rx_cnt = 0;
        und_cnt = 0;
        select_t();
        xfer(8'h12, 1'b0, 8, m1, p0, p1);
        xfer(8'h34, 1'b0, 8, m2, p0, p1);
        deselect_t();
        check("two_idle_miso0", 32'(m1), 32'hFF);
        check("two_idle_miso1", 32'(m2), 32'hFF);
        check("two_idle_underruns", 32'(und_cnt), 32'd2);
        check("two_idle_rx_pulses", 32'(rx_cnt), 32'd2);
        check("two_idle_rx_data", 32'(RX_DATA), 32'h34);

        // Peeked byte without any SCK stays in holding.
        load(8'h11);
        select_t();
        check("peek_sel", 32'(SEL), 32'd1);
        check("peek_miso_oe", 32'(MISO_OE), 32'd1);
        check("peek_miso_bit7", 32'(MISO), 32'd0);
        deselect_t();
        check("peek_ready_kept", 32'(TX_READY), 32'd0);
        check("peek_oe_off", 32'(MISO_OE), 32'd0);
        und_cnt = 0;
        select_t();
        xfer(8'h00, 1'b0, 8, m1, p0, p1);
        deselect_t();
        check("peek_sent_later", 32'(m1), 32'h11);
        check("peek_no_underrun", 32'(und_cnt), 32'd0);

        // Abort after five bits, then a clean byte.
        rx_cnt = 0;
        select_t();
        xfer(8'hF0, 1'b0, 5, m1, p0, p1);
        deselect_t();
        check("abort_no_rx", 32'(rx_cnt), 32'd0);
        check("abort_oe_off", 32'(MISO_OE), 32'd0);
        check("abort_miso_high", 32'(MISO), 32'd1);
        select_t();
        xfer(8'h5A, 1'b0, 8, m1, p0, p1);
        deselect_t();
        check("abort_next_rx", 32'(RX_DATA), 32'h5A);
        check("abort_next_pulses", 32'(rx_cnt), 32'd1);

        // Back-to-back with refill during the first byte.
        und_cnt = 0;
        load(8'h01);
        select_t();
        fork
            xfer(8'h00, 1'b0, 8, m1, p0, p1);
            load(8'h80);
        join
        xfer(8'h00, 1'b0, 8, m2, p0, p1);
        deselect_t();
        check("b2b_first", 32'(m1), 32'h01);
        check("b2b_second", 32'(m2), 32'h80);
        check("b2b_no_underrun", 32'(und_cnt), 32'd0);

        // Reset in the middle of a byte with holding full.
        load(8'hAA);
        select_t();
        xfer(8'hFF, 1'b0, 3, m1, p0, p1);
        nRESET = 1'b0;
        wclk(1);
        check("mid_rst_miso", 32'(MISO), 32'd1);
        check("mid_rst_oe", 32'(MISO_OE), 32'd0);
        check("mid_rst_ready", 32'(TX_READY), 32'd1);
        check("mid_rst_rx_data", 32'(RX_DATA), 32'h00);
        check("mid_rst_rx_valid", 32'(RX_VALID), 32'd0);
        check("mid_rst_underrun", 32'(TX_UNDERRUN), 32'd0);
        check("mid_rst_sel", 32'(SEL), 32'd0);
        nSS = 1'b1;
        SCK = 1'b0;
        wclk(6);
        nRESET = 1'b1;
        wclk(4);
        check("post_rst_sel", 32'(SEL), 32'd0);

`ifdef SPI_TARGET_MODE3_EN
        MODE3 = 1'b1;
        SCK = 1'b1;
        wclk(10);
        rx_cnt = 0;
        load(8'h96);
        select_t();
        xfer(8'hC3, 1'b1, 8, m1, p0, p1);
        deselect_t();
        check("mode3_rx_data", 32'(RX_DATA), 32'hC3);
        check("mode3_miso", 32'(m1), 32'h96);
        check("mode3_rx_pulses", 32'(rx_cnt), 32'd1);
        SCK = 1'b0;
        MODE3 = 1'b0;
        wclk(10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
